tanh_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one Tanh activation unit (start/done pulse interface) among NUM_REQ layer controllers in the MNIST accelerator.
- Grants one requester at a time and drives `sel` so the external wide data mux routes that requester's 32b accumulator vector into the unit.
- Sequences the unit's start pulse and returns a per-requester completion pulse.
- Runs a watchdog so a hung unit cannot deadlock the layer pipeline.

---
 rtl/tanh_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_tanh_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_arbiter.sv
// tanh_arbiter
// Round-robin arbiter and sequencer sharing one Tanh activation unit among
// NUM_REQ layer controllers. It grants one requester at a time, drives sel_o
// for the external wide data/result mux, pulses the unit's start, returns a
// per-requester completion pulse, and aborts a hung unit with a watchdog.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   req_i          per-requester level request, held until its req_done pulse
//   grant_o        one-hot grant (at most one bit set)
//   sel_o          index of the granted requester
//   req_done_o     one-cycle completion pulse to the granted requester
//   act_start_o    one-cycle start pulse to the Tanh unit
//   act_done_i     one-cycle done pulse from the Tanh unit
//   busy_o         high whenever the sequencer is not idle
//   timeout_err_o  sticky watchdog error, cleared only by reset
//   timeout_id_o   requester index captured at the most recent timeout
//
// Every output comes straight from a register; there is no combinational
// path from an input to an output.
module tanh_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SEL_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic [NUM_REQ-1:0]   req_done_o,
  output logic                 act_start_o,
  input  logic                 act_done_i,
  output logic                 busy_o,
  output logic                 timeout_err_o,
  output logic [SEL_WIDTH-1:0] timeout_id_o
);

  // The watchdog count never needs to exceed TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_REQ - 1);
  localparam bit                   WD_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic                 act_start_q, act_start_d;
  logic                 busy_q, busy_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [SEL_WIDTH-1:0] timeout_id_q, timeout_id_d;
  logic [CNT_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic [SEL_WIDTH-1:0] last_q, last_d;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First set request searching upward from last+1 with wrap. Walking the
  // offsets from farthest to nearest lets the nearest hit overwrite the rest.
  function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0]   req,
                                                   input logic [SEL_WIDTH-1:0] last);
    logic [SEL_WIDTH-1:0] win;
    int                   idx;
    win = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req[SEL_WIDTH'(idx)]) begin
        win = SEL_WIDTH'(idx);
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    sel_d         = sel_q;
    req_done_d    = '0;
    act_start_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    timeout_id_d  = timeout_id_q;
    wd_cnt_d      = wd_cnt_q;
    last_d        = last_q;

    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          sel_d   = rr_pick(req_i, last_q);
          grant_d = onehot(sel_d);
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      // Settle cycle for the external mux; the start pulse is registered
      // here so it is high for the whole START cycle.
      S_GRANT: begin
        act_start_d = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        wd_cnt_d = '0;
        state_d  = S_WAIT;
      end
      // act_done takes priority over a watchdog expiry in the same cycle.
      S_WAIT: begin
        if (act_done_i) begin
          req_done_d = onehot(sel_q);
          state_d    = S_RELEASE;
        end else if (WD_EN && (wd_cnt_q == CNT_LAST)) begin
          timeout_err_d = 1'b1;
          timeout_id_d  = sel_q;
          req_done_d    = onehot(sel_q);
          state_d       = S_RELEASE;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        last_d  = sel_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      sel_q         <= '0;
      req_done_q    <= '0;
      act_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
      wd_cnt_q      <= '0;
      last_q        <= SEL_LAST;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      sel_q         <= sel_d;
      req_done_q    <= req_done_d;
      act_start_q   <= act_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
      wd_cnt_q      <= wd_cnt_d;
      last_q        <= last_d;
    end
  end

  assign grant_o       = grant_q;
  assign sel_o         = sel_q;
  assign req_done_o    = req_done_q;
  assign act_start_o   = act_start_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = timeout_err_q;
  assign timeout_id_o  = timeout_id_q;

endmodule

// File: tb/tb_tanh_arbiter.sv
// Testbench for tanh_arbiter. The bench plays the role of the requesters and
// of the shared Tanh unit. Expected behaviour comes from a transaction-level
// model: a pending-request set, a round-robin pointer, and the documented
// cycle timeline of one grant/start/wait/release transaction.
module tb_tanh_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       act_done = 1'b0;
  logic [3:0] grant, req_done;
  logic [1:0] sel, timeout_id;
  logic       act_start, busy, timeout_err;

  // Second instance with the watchdog disabled.
  logic [3:0] req2 = 4'b0000;
  logic       act_done2 = 1'b0;
  logic [3:0] grant2, req_done2;
  logic [1:0] sel2, timeout_id2;
  logic       act_start2, busy2, timeout_err2;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [3:0] pending;
  int         ptr;
  logic       m_err;
  int         m_id;

  always #5 clk = ~clk;

  tanh_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .grant_o(grant), .sel_o(sel),
    .req_done_o(req_done), .act_start_o(act_start), .act_done_i(act_done),
    .busy_o(busy), .timeout_err_o(timeout_err), .timeout_id_o(timeout_id));

  tanh_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(0)) u_dut_nowd (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .grant_o(grant2), .sel_o(sel2),
    .req_done_o(req_done2), .act_start_o(act_start2), .act_done_i(act_done2),
    .busy_o(busy2), .timeout_err_o(timeout_err2), .timeout_id_o(timeout_id2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; act_done = 1'b0; pending = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    ptr = NREQ - 1; m_err = 1'b0; m_id = 0;
  endtask

  // One full transaction starting with the DUT idle and req == pending.
  // lat: cycles from act_start to act_done (>TO or hang means the watchdog fires)
  // stray: drive act_done during GRANT and START, which must be ignored
  // add: requests raised at the moment the winner drops its request
  task automatic run_txn(input int lat, input bit hang, input bit stray, input logic [3:0] add);
    int         w;
    int         n_wait;
    bit         to_hit;
    logic [3:0] oh;
    w = 0;
    for (int k = NREQ; k >= 1; k--) begin
      if (pending[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
    end
    oh = 4'b0001 << w;

    tick();
    chk("grant", grant, oh);
    chk("sel", sel, w);
    chk("busy", busy, 1);
    chk("start_early", act_start, 0);
    act_done = stray;
    tick();
    chk("start_hi", act_start, 1);
    chk("grant_hold", grant, oh);
    act_done = stray;
    tick();
    act_done = 1'b0;
    chk("start_pulse", act_start, 0);

    to_hit = hang || (lat > TO);
    n_wait = to_hit ? TO : lat;
    for (int c = 1; c <= n_wait; c++) begin
      act_done = (!to_hit && c == lat);
      chk("wait_no_done", req_done, 0);
      chk("wait_grant", grant, oh);
      tick();
      act_done = 1'b0;
    end

    if (to_hit) begin
      m_err = 1'b1;
      m_id  = w;
    end
    chk("req_done", req_done, oh);
    chk("rel_grant", grant, oh);
    chk("timeout_err", timeout_err, m_err);
    chk("timeout_id", timeout_id, m_id);
    pending = (pending & ~oh) | add;
    req     = pending;
    ptr     = w;
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_done", req_done, 0);
    chk("idle_busy", busy, 0);
    chk("sel_hold", sel, w);
  endtask

  initial begin
    bit early;

    // Reset state
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_sel", sel, 0);
    chk("rst_done", req_done, 0);
    chk("rst_start", act_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_tid", timeout_id, 0);

    // Stray act_done while idle
    act_done = 1'b1;
    tick();
    act_done = 1'b0;
    chk("stray_idle_busy", busy, 0);
    tick();
    chk("stray_idle_grant", grant, 0);
    chk("stray_idle_done", req_done, 0);

    // Single request, latency 10
    pending = 4'b0100; req = pending;
    run_txn(10, 1'b0, 1'b0, 4'b0000);

    // Fairness: all four held continuously, latency 5 -> 0,1,2,3,0,1
    do_reset();
    pending = 4'b1111; req = pending;
    for (int i = 0; i < 5; i++) run_txn(5, 1'b0, 1'b0, 4'b1111);
    run_txn(5, 1'b0, 1'b0, 4'b0000);

    // Pointer wrap: serve 2, then 3 while raising 1001 -> 0 then 3
    run_txn(4, 1'b0, 1'b0, 4'b0000);
    run_txn(4, 1'b0, 1'b0, 4'b1001);
    chk("wrap_pending", req, 4'b1001);
    run_txn(3, 1'b0, 1'b0, 4'b0000);
    run_txn(3, 1'b0, 1'b0, 4'b0000);

    // act_done in the same cycle as the watchdog expiry, then one just before
    pending = 4'b0001; req = pending;
    run_txn(TO, 1'b0, 1'b0, 4'b0000);
    pending = 4'b0100; req = pending;
    run_txn(TO - 1, 1'b0, 1'b0, 4'b0000);

    // Stray act_done during GRANT/START
    pending = 4'b1000; req = pending;
    run_txn(7, 1'b0, 1'b1, 4'b0000);

    // Watchdog: unit never answers, then a normal transaction keeps the error
    pending = 4'b0010; req = pending;
    run_txn(0, 1'b1, 1'b0, 4'b0000);
    pending = 4'b0100; req = pending;
    run_txn(3, 1'b0, 1'b0, 4'b0000);

    // Randomized transactions
    for (int i = 0; i < 16; i++) begin
      if (pending == 4'b0000) begin
        pending = 4'b0001 << $urandom_range(3, 0);
        req     = pending;
      end
      run_txn(int'($urandom_range(20, 1)), ($urandom_range(7, 0) == 0),
              1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
    end
    pending = 4'b0000; req = pending;
    tick(); tick();

    // Watchdog disabled, 10000-cycle unit
    req2 = 4'b0001;
    tick();
    chk("nowd_grant", grant2, 4'b0001);
    tick();
    chk("nowd_start", act_start2, 1);
    tick();
    early = 1'b0;
    for (int c = 1; c <= 10000; c++) begin
      act_done2 = (c == 10000);
      if (req_done2 != 4'b0000) early = 1'b1;
      tick();
      act_done2 = 1'b0;
    end
    chk("nowd_early", early, 0);
    chk("nowd_done", req_done2, 4'b0001);
    chk("nowd_terr", timeout_err2, 0);
    req2 = 4'b0000;
    tick();
    chk("nowd_release", grant2, 0);

    // Reset mid-WAIT while requester 1 is granted
    pending = 4'b0010; req = pending;
    tick();
    chk("mid_grant", grant, 4'b0010);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_done", req_done, 0);
    chk("mid_rst_start", act_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_tid", timeout_id, 0);
    ptr = NREQ - 1; m_err = 1'b0; m_id = 0;
    pending = 4'b0011; req = pending;
    run_txn(2, 1'b0, 1'b0, 4'b0000);
    run_txn(2, 1'b0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
